// File: rtl/sync_event_pkg.sv
// ============================================================================
//  Module      : sync_event_pkg
//  Description : Shared types and default constants for the synchronized
//                event capture block (level filter, accumulator and
//                snapshot handshake).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sync_event_pkg;

    // Default accumulator / snapshot width.
    localparam int SYNC_EVT_CNT_W    = 8;

    // Default number of consecutive differing samples needed to flip the
    // filtered level.
    localparam int SYNC_EVT_FILT_LEN = 2;

    // Output snapshot FSM.
    //   ST_IDLE : no snapshot presented, waiting for pending events
    //   ST_HOLD : snapshot presented on evt_valid, waiting for evt_ready
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } evt_state_e;

endpackage : sync_event_pkg

`default_nettype wire

// File: rtl/sync_event_capture_level_filter.sv
// ============================================================================
//  Module      : level_filter
//  Description : Glitch filter and rising-edge detector for a single-bit
//                level that is already synchronous to clk_fast.
//                The filtered level only changes after FILT_LEN consecutive
//                samples that differ from it; a registered one-cycle pulse
//                marks each accepted 0->1 transition.
//  Revision    : 1.0 - initial release
//
//  Parameters
//    FILT_LEN   : consecutive differing samples needed to flip the level
//                 (>= 1; 1 disables filtering)
//
//  Ports
//    clk_fast   in   1  clock, rising edge
//    rst_n      in   1  asynchronous active-low reset
//    data_in    in   1  synchronized level
//    level_out  out  1  filtered level, reset 0
//    rise_pulse out  1  one-cycle pulse on the edge level_out goes 0->1
// ============================================================================
`default_nettype none

module level_filter
    import sync_event_pkg::*;
#(
    parameter int FILT_LEN = SYNC_EVT_FILT_LEN
) (
    input  logic clk_fast,
    input  logic rst_n,
    input  logic data_in,
    output logic level_out,
    output logic rise_pulse
);

    localparam int              c_cnt_w = $clog2(FILT_LEN + 1);
    // Count value at which the next differing sample is the FILT_LEN-th.
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(FILT_LEN - 1);

    logic [c_cnt_w-1:0] cnt_q;
    logic [c_cnt_w-1:0] cnt_d;
    logic               level_q;
    logic               level_d;
    logic               rise_q;
    logic               rise_d;

    // The run counter only advances while the input disagrees with the
    // filtered level; any agreeing sample restarts the run, so a glitch
    // shorter than FILT_LEN never reaches the output.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        rise_d  = 1'b0;
        if (data_in != level_q) begin
            if (cnt_q == c_last) begin
                level_d = ~level_q;
                // Pulse only on the 0->1 flip; falls are silent.
                rise_d  = ~level_q;
            end else begin
                cnt_d = cnt_q + c_cnt_w'(1);
            end
        end
    end

    always_ff @(posedge clk_fast or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
        end
    end

    assign level_out  = level_q;
    assign rise_pulse = rise_q;

endmodule : level_filter

`default_nettype wire

// File: rtl/sync_event_capture.sv
// ============================================================================
//  Module      : sync_event_capture
//  Description : Fast-domain consumer of a synchronized single-bit level.
//                Filters the level, turns accepted rising edges into event
//                pulses, accumulates them in a saturating counter with a
//                sticky overflow flag, and hands count snapshots to a reader
//                over a valid/ready handshake without losing events at the
//                hand-off.
//  Revision    : 1.0 - initial release
//
//  Parameters
//    CNT_W      : accumulator / snapshot width (>= 2)
//    FILT_LEN   : glitch filter length in cycles (>= 1)
//
//  Ports
//    clk_fast   in   1      clock, rising edge
//    rst_n      in   1      asynchronous active-low reset
//    data_in    in   1      synchronized level
//    level_out  out  1      filtered level
//    evt_pulse  out  1      one-cycle pulse per accepted rising edge
//    evt_valid  out  1      snapshot available
//    evt_ready  in   1      reader accepts snapshot
//    evt_count  out  CNT_W  events in snapshot
//    evt_ovf    out  1      snapshot saturated, events were lost
// ============================================================================
`default_nettype none

module sync_event_capture
    import sync_event_pkg::*;
#(
    parameter int CNT_W    = SYNC_EVT_CNT_W,
    parameter int FILT_LEN = SYNC_EVT_FILT_LEN
) (
    input  logic             clk_fast,
    input  logic             rst_n,
    input  logic             data_in,
    output logic             level_out,
    output logic             evt_pulse,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [CNT_W-1:0] evt_count,
    output logic             evt_ovf
);

    // ------------------------------------------------------------------
    // Filter and edge detector
    // ------------------------------------------------------------------
    logic rise_pulse;

    level_filter #(
        .FILT_LEN   (FILT_LEN)
    ) u_level_filter (
        .clk_fast   (clk_fast),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .level_out  (level_out),
        .rise_pulse (rise_pulse)
    );

    assign evt_pulse = rise_pulse;

    // ------------------------------------------------------------------
    // Accumulator
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] acc_q;
    logic [CNT_W-1:0] acc_d;
    logic             acc_ovf_q;
    logic             acc_ovf_d;

    evt_state_e       state_q;
    logic             evt_valid_q;
    logic [CNT_W-1:0] evt_count_q;
    logic             evt_ovf_q;

    // A snapshot is taken from IDLE whenever anything is pending. The
    // overflow term is kept for clarity; a set overflow implies a full acc.
    logic snap_load;
    assign snap_load = (state_q == ST_IDLE) && ((acc_q != '0) || acc_ovf_q);

    always_comb begin
        acc_d     = acc_q;
        acc_ovf_d = acc_ovf_q;
        if (snap_load) begin
            // The snapshot takes the old acc; a pulse arriving on the same
            // edge starts the next batch so nothing is dropped.
            acc_d     = {{(CNT_W-1){1'b0}}, evt_pulse};
            acc_ovf_d = 1'b0;
        end else if (evt_pulse) begin
            if (&acc_q) begin
                acc_ovf_d = 1'b1;
            end else begin
                acc_d = acc_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_fast or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= '0;
            acc_ovf_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            acc_ovf_q <= acc_ovf_d;
        end
    end

    // ------------------------------------------------------------------
    // Output snapshot FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk_fast or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            evt_valid_q <= 1'b0;
            evt_count_q <= '0;
            evt_ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // evt_ready is deliberately not looked at here.
                    if (snap_load) begin
                        evt_count_q <= acc_q;
                        evt_ovf_q   <= acc_ovf_q;
                        evt_valid_q <= 1'b1;
                        state_q     <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    // Snapshot registers stay frozen; returning through IDLE
                    // guarantees at least one low cycle of evt_valid.
                    if (evt_valid_q && evt_ready) begin
                        evt_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    evt_valid_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign evt_valid = evt_valid_q;
    assign evt_count = evt_count_q;
    assign evt_ovf   = evt_ovf_q;

endmodule : sync_event_capture

`default_nettype wire

// File: tb/tb_sync_event_capture.sv
// ============================================================================
//  Module      : tb_sync_event_capture
//  Description : Self-checking bench for sync_event_capture. Two instances:
//                u_dut0 (CNT_W=8, FILT_LEN=2) and u_dut1 (CNT_W=2,
//                FILT_LEN=2, for saturation). A behavioural model built from
//                sample history and an unbounded pending-event count is
//                compared every cycle; directed tables and sequences cover
//                the corner cases.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_sync_event_capture;

    localparam int F  = 2;
    localparam int W0 = 8;
    localparam int W1 = 2;

    logic clk_fast = 1'b0;
    logic rst_n    = 1'b0;
    logic d0 = 1'b0, r0 = 1'b0, d1 = 1'b0, r1 = 1'b0;

    logic          lvl0, pul0, val0, ovf0;
    logic [W0-1:0] cnt0;
    logic          lvl1, pul1, val1, ovf1;
    logic [W1-1:0] cnt1;

    int checks = 0;
    int errors = 0;

    always #5 clk_fast = ~clk_fast;

    sync_event_capture #(.CNT_W(W0), .FILT_LEN(F)) u_dut0 (
        .clk_fast (clk_fast), .rst_n (rst_n), .data_in (d0),
        .level_out(lvl0), .evt_pulse(pul0), .evt_valid(val0),
        .evt_ready(r0), .evt_count(cnt0), .evt_ovf(ovf0)
    );

    sync_event_capture #(.CNT_W(W1), .FILT_LEN(F)) u_dut1 (
        .clk_fast (clk_fast), .rst_n (rst_n), .data_in (d1),
        .level_out(lvl1), .evt_pulse(pul1), .evt_valid(val1),
        .evt_ready(r1), .evt_count(cnt1), .evt_ovf(ovf1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_fast);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Reference model: level flips when the last F samples all disagree
    // with it; events pending since the last snapshot are an unbounded
    // integer, clipped to the counter range only when a snapshot is taken.
    // ------------------------------------------------------------------
    int m_level[2], m_pulse[2], m_pend[2], m_valid[2], m_cnt[2], m_ovf[2], m_nh[2];
    bit m_hist[2][16];

    task automatic model_reset(input int m);
        m_level[m] = 0; m_pulse[m] = 0; m_pend[m] = 0;
        m_valid[m] = 0; m_cnt[m] = 0; m_ovf[m] = 0; m_nh[m] = 0;
    endtask

    task automatic model_step(input int m, input bit d, input bit r, input int flen, input int maxv);
        bit tog;
        int pul_cur;
        for (int k = 15; k > 0; k--) m_hist[m][k] = m_hist[m][k-1];
        m_hist[m][0] = d;
        if (m_nh[m] < 16) m_nh[m]++;
        tog = (m_nh[m] >= flen);
        for (int k = 0; k < flen; k++)
            if (int'(m_hist[m][k]) == m_level[m]) tog = 0;

        pul_cur = m_pulse[m];
        if (m_valid[m] == 0 && m_pend[m] > 0) begin
            m_cnt[m]   = (m_pend[m] > maxv) ? maxv : m_pend[m];
            m_ovf[m]   = (m_pend[m] > maxv) ? 1 : 0;
            m_valid[m] = 1;
            m_pend[m]  = pul_cur;
        end else begin
            if (m_valid[m] != 0 && r) m_valid[m] = 0;
            m_pend[m] = m_pend[m] + pul_cur;
        end

        m_pulse[m] = (tog && m_level[m] == 0) ? 1 : 0;
        if (tog) m_level[m] = 1 - m_level[m];
    endtask

    function automatic logic [11:0] mpack(input int m);
        logic [31:0] c;
        c = m_cnt[m];
        return {m_level[m][0], m_pulse[m][0], m_valid[m][0], m_ovf[m][0], c[7:0]};
    endfunction

    always @(posedge clk_fast or negedge rst_n) begin
        if (!rst_n) begin
            model_reset(0);
            model_reset(1);
        end else begin
            model_step(0, d0, r0, F, (1 << W0) - 1);
            model_step(1, d1, r1, F, (1 << W1) - 1);
        end
    end

    always @(negedge clk_fast) begin
        check("model_dut0", {lvl0, pul0, val0, ovf0, cnt0}, mpack(0));
        check("model_dut1", {lvl1, pul1, val1, ovf1, 6'b0, cnt1}, mpack(1));
    end

    // ------------------------------------------------------------------
    // Directed vectors: single event, glitch, dip inside a long high
    // ------------------------------------------------------------------
    typedef struct {
        logic       d;
        logic       r;
        logic       lvl;
        logic       pul;
        logic       val;
        logic [7:0] cnt;
        logic       ovf;
    } vec_t;

    vec_t tbl[16];

    task automatic check_zero(input string name);
        check({name, "_dut0"}, {lvl0, pul0, val0, ovf0, cnt0}, 12'h000);
        check({name, "_dut1"}, {lvl1, pul1, val1, ovf1, cnt1}, 6'h00);
    endtask

    task automatic evt(input int m, input int hi, input int lo);
        if (m == 0) d0 = 1'b1; else d1 = 1'b1;
        repeat (hi) step();
        if (m == 0) d0 = 1'b0; else d1 = 1'b0;
        repeat (lo) step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int npul;
        int sum;
        int run0;
        int run1;

        //            d     r     lvl   pul   val   cnt   ovf
        tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd1, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1, 1'b0};
        tbl[11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd1, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1, 1'b0};
        tbl[13] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'd1, 1'b0};
        tbl[14] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1, 1'b0};
        tbl[15] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1, 1'b0};

        // ---------------- reset, including mid-filter ----------------
        repeat (3) step();
        check_zero("reset_state");
        rst_n = 1'b1;
        d0 = 1'b1;
        step();                       // filter run in progress
        #2 rst_n = 1'b0;
        #1 check_zero("reset_midfilter");
        rst_n = 1'b1;
        step();
        check("rst_release_lvl_e1", lvl0, 1'b0);
        step();
        check("rst_release_lvl_e2", {lvl0, pul0}, 2'b11);
        d0 = 1'b0;
        r0 = 1'b1;
        repeat (6) step();
        rst_n = 1'b0;
        repeat (2) step();
        r0 = 1'b0;
        rst_n = 1'b1;

        // ---------------- table-driven vectors ----------------
        npul = 0;
        for (int i = 0; i < 16; i++) begin
            d0 = tbl[i].d;
            r0 = tbl[i].r;
            step();
            check($sformatf("tbl%0d", i), {lvl0, pul0, val0, cnt0, ovf0},
                  {tbl[i].lvl, tbl[i].pul, tbl[i].val, tbl[i].cnt, tbl[i].ovf});
            if (pul0) npul++;
            if (i == 9) check("single_event_pulses", npul, 1);
        end
        check("table_pulses_total", npul, 2);

        // ---------------- backpressure accumulation ----------------
        d0 = 1'b0;
        r0 = 1'b0;
        repeat (4) step();
        for (int i = 0; i < 5; i++) evt(0, 3, 3);
        check("bp_first_snap", {val0, cnt0, ovf0}, {1'b1, 8'd1, 1'b0});
        r0 = 1'b1;
        step();
        r0 = 1'b0;
        check("bp_transfer", val0, 1'b0);
        step();
        check("bp_second_snap", {val0, cnt0, ovf0}, {1'b1, 8'd4, 1'b0});
        r0 = 1'b1;
        step();
        r0 = 1'b0;
        check("bp_second_transfer", val0, 1'b0);

        // ---------------- saturation (CNT_W = 2) ----------------
        evt(1, 3, 3);
        check("sat_first_snap", {val1, cnt1, ovf1}, {1'b1, 2'd1, 1'b0});
        for (int i = 0; i < 6; i++) evt(1, 3, 3);
        check("sat_hold_stable", {val1, cnt1, ovf1}, {1'b1, 2'd1, 1'b0});
        r1 = 1'b1;
        step();
        r1 = 1'b0;
        check("sat_transfer", val1, 1'b0);
        step();
        check("sat_second_snap", {val1, cnt1, ovf1}, {1'b1, 2'd3, 1'b1});
        r1 = 1'b1;
        step();
        r1 = 1'b0;
        evt(1, 3, 3);
        check("sat_third_snap", {val1, cnt1, ovf1}, {1'b1, 2'd1, 1'b0});
        r1 = 1'b1;
        step();
        r1 = 1'b0;

        // ---------------- hand-off race ----------------
        evt(0, 3, 3);
        check("race_snap_a", {val0, cnt0}, {1'b1, 8'd1});
        sum = int'(cnt0);
        evt(0, 3, 3);                 // second event waits in acc
        d0 = 1'b1;
        step();                       // E0 of third event
        r0 = 1'b1;
        step();                       // transfer edge, third pulse now high
        r0 = 1'b0;
        check("race_pulse_at_transfer", {pul0, val0}, 2'b10);
        step();                       // load edge coincides with the pulse
        check("race_snap_b", {val0, cnt0}, {1'b1, 8'd1});
        sum += int'(cnt0);
        r0 = 1'b1;
        step();
        r0 = 1'b0;
        check("race_transfer_b", val0, 1'b0);
        step();
        check("race_snap_c", {val0, cnt0}, {1'b1, 8'd1});
        sum += int'(cnt0);
        r0 = 1'b1;
        step();
        r0 = 1'b0;
        d0 = 1'b0;
        repeat (4) step();
        check("race_no_extra_snap", val0, 1'b0);
        check("race_total", sum, 3);

        // ---------------- randomized against the model ----------------
        run0 = 0;
        run1 = 0;
        for (int c = 0; c < 3000; c++) begin
            if (run0 == 0) begin
                d0   = ~d0;
                run0 = int'($urandom_range(1, 5));
            end
            if (run1 == 0) begin
                d1   = ~d1;
                run1 = int'($urandom_range(1, 4));
            end
            run0--;
            run1--;
            r0 = ($urandom_range(0, 3) != 0);
            r1 = ($urandom_range(0, 7) == 0);
            if (c == 1500) begin
                #2 rst_n = 1'b0;
                #1 check_zero("reset_random");
                #2 rst_n = 1'b1;
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_sync_event_capture

`default_nettype wire

// File: doc/sync_event_capture.md
# sync_event_capture

Fast-domain consumer of a single-bit synchronizer output (e.g. `slow2fast_sync.data_out`). Glitch-filters the synchronized level, converts each accepted rising edge into a one-cycle event pulse, accumulates events in a saturating counter, and hands count snapshots to a downstream reader over a valid/ready handshake. Software or control logic can therefore sample bursts of cross-domain events without losing any to backpressure, or is told explicitly via an overflow flag when events were lost.

## Interface
- `CNT_W`, 8: width of the event accumulator and of the snapshot; must be ≥ 2.
- `FILT_LEN`, 2: consecutive identical samples required before the filtered level changes; must be ≥ 1. 1 means no filtering.

- `clk_fast`  in  1  sole clock; all logic is on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `data_in`  in  1  level already synchronized into `clk_fast`; treated as synchronous.
- `level_out`  out  1  filtered level; reset 0.
- `evt_pulse`  out  1  one-cycle pulse per accepted rising edge of `level_out`; reset 0.
- `evt_valid`  out  1  snapshot available; reset 0.
- `evt_ready`  in  1  reader accepts snapshot.
- `evt_count`  out  CNT_W  events in snapshot; reset 0.
- `evt_ovf`  out  1  snapshot saturated, so events were lost; reset 0.

## Operation
- Filter: a counter runs while `data_in != level_out` and clears whenever the two are equal. On the edge that takes the FILT_LEN-th consecutive differing sample, `level_out` toggles and the counter clears.
- Edge: `evt_pulse` is registered high on the same edge that `level_out` goes 0→1. Falling transitions produce no pulse.
- Accumulator `acc` (CNT_W) with sticky `acc_ovf`:
  - `evt_pulse` increments `acc`.
  - At all-ones, `acc` holds and `acc_ovf` is set.
- Output FSM, states IDLE and HOLD:
  - IDLE: when `acc != 0` or `acc_ovf`:
    - load `evt_count <= acc`, `evt_ovf <= acc_ovf`, set `evt_valid`, go to HOLD.
    - Simultaneously reload `acc` to the value of `evt_pulse` (0 or 1) and clear `acc_ovf`. No event is lost at the hand-off.
  - HOLD: `evt_count`, `evt_ovf` and `evt_valid` stay stable. New events keep accumulating in `acc`. When `evt_valid && evt_ready`, clear `evt_valid` and return to IDLE.
  - `evt_ready` is ignored in IDLE.
- `evt_count`/`evt_ovf` keep their last value after a transfer. They are meaningful only while `evt_valid`.
- Asserting `rst_n` at any time, including mid-filter or in HOLD, immediately:
  - returns every output to its reset value;
  - clears `acc`, `acc_ovf` and the filter counter;
  - sets the FSM to IDLE.
- Pending events are discarded.

## Timing
- Edge E0 is the first edge that samples `data_in` high while `level_out = 0`, with the level sustained:
  - `level_out` = 1 and `evt_pulse` = 1 after edge E0+FILT_LEN−1.
  - `acc` = 1 after edge E0+FILT_LEN.
  - `evt_valid` = 1 after edge E0+FILT_LEN+1, provided the FSM is in IDLE.
- Minimum `data_in` high time for detection is FILT_LEN cycles. A high time of FILT_LEN−1 or less is rejected. The same rule applies to low time.
- Maximum accepted event rate is one per 2·FILT_LEN cycles.
- Handshake: the transfer occurs on the edge where `evt_valid && evt_ready`. `evt_valid` is low for at least one cycle between snapshots. Back-to-back snapshots are spaced at least 2 cycles apart.
- Simultaneous `evt_pulse` and a snapshot load: the pulse is counted in the new `acc`, not in the snapshot.
- Simultaneous `evt_pulse` with `acc` at all-ones: `acc` holds and `acc_ovf` is set.

## Structure
- Package `sync_event_pkg`:
  - output FSM state enum (`ST_IDLE`, `ST_HOLD`);
  - default constants `SYNC_EVT_CNT_W = 8`, `SYNC_EVT_FILT_LEN = 2`.
- Sub-module `level_filter` (params FILT_LEN; ports `clk_fast`, `rst_n`, `data_in`, `level_out`, `rise_pulse`) implements the filter and edge detector.
- The top level holds the accumulator and output FSM.
- Counter width inside `level_filter` is `$clog2(FILT_LEN+1)`.

## Test plan
- **Reset:** drive `data_in` = 1, then assert `rst_n` low mid-filter → all outputs 0. After release, `level_out` rises FILT_LEN edges later.
- **Single event:** FILT_LEN = 2, `data_in` high for 3 cycles (one slow-clock pulse from `slow2fast_sync`), `evt_ready` = 1 → exactly one `evt_pulse`. `evt_valid` asserts with `evt_count` = 1 and `evt_ovf` = 0, and is cleared one cycle later.
- **Glitch:** 1-cycle high on `data_in` with FILT_LEN = 2 → `level_out`, `evt_pulse` and `evt_valid` stay 0. A 1-cycle low dip inside a long high produces no second pulse.
- **Backpressure accumulation:** `evt_ready` = 0, 5 events spaced 6 cycles apart:
  - first snapshot reads `evt_count` = 1;
  - raise `evt_ready` → transfer, then next snapshot `evt_count` = 4.
- **Saturation:** CNT_W = 2, `evt_ready` = 0 during the first snapshot, then 6 more events → second snapshot has `evt_count` = 3 and `evt_ovf` = 1. Next snapshot after one more event has `evt_count` = 1 and `evt_ovf` = 0.
- **Hand-off race:** align an `evt_pulse` with the IDLE→HOLD load edge → snapshot excludes it, and the following snapshot includes it. The total count across snapshots equals the number of pulses.
